// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS controller: state encoding,
// opcode/funct fields, ALU op classes and the per-state control word.
package mc_pkg;

    localparam int STATEW = 4;

    typedef enum logic [STATEW-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        BNEEX   = 4'd12
    } statetype;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Everything a state drives; branch_ne is only ever set when bne support is built in.
    typedef struct packed {
        logic       lord;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       memwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
        logic       branch_ne;
        aluop_t     aluop;
    } ctrl_t;

endpackage

// File: rtl/multicycle_controller_aludec.sv
// ALU decoder: maps the FSM's aluop class plus the R-type funct field to the
// 3-bit ALU operation. Purely combinational.
module aludec
    import mc_pkg::*;
#(
    parameter logic [2:0] ALU_DFLT = ALU_ADD
) (
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        // NOTE: default first so every path assigns alucontrol and no latch is inferred.
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD:  alucontrol = ALU_ADD;
            ALUOP_SUB:  alucontrol = ALU_SUB;
            ALUOP_RSVD: alucontrol = ALU_ADD;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_DFLT;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath. Define MC_BNE_EN to add
// the bne instruction (state BNEEX); by default op 000101 decodes as a nop.
module multicycle_controller #(
    parameter logic [2:0] ALU_DFLT = mc_pkg::ALU_ADD,
    parameter int         STATEW   = mc_pkg::STATEW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        op,
    input  logic [5:0]        funct,
    input  logic              zero,
    output logic              lord,
    output logic              irwrite,
    output logic              regdst,
    output logic              memtoreg,
    output logic              regwrite,
    output logic              memwrite,
    output logic              alusrca,
    output logic [1:0]        alusrcb,
    output logic [2:0]        alucontrol,
    output logic [1:0]        pcsrc,
    output logic              pcen,
    output logic [STATEW-1:0] state
);

    import mc_pkg::*;

    statetype state_q;
    statetype state_d;
    ctrl_t    ctrl;

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignment for state so every flop samples pre-edge values.
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = BNEEX;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = MEMWB;
            RTYPEEX: state_d = RTYPEWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // Outputs are held at their idle values while reset is asserted, so the
    // FETCH decode cannot pulse irwrite/pcen before the first real edge.
    always_comb begin
        ctrl       = '0;
        ctrl.aluop = ALUOP_ADD;
        if (reset) begin
            case (state_q)
                FETCH: begin
                    ctrl.alusrcb = 2'b01;
                    ctrl.irwrite = 1'b1;
                    ctrl.pcwrite = 1'b1;
                end
                DECODE:  ctrl.alusrcb = 2'b11;
                MEMADR, ADDIEX: begin
                    ctrl.alusrca = 1'b1;
                    ctrl.alusrcb = 2'b10;
                end
                MEMRD:   ctrl.lord = 1'b1;
                MEMWB: begin
                    ctrl.memtoreg = 1'b1;
                    ctrl.regwrite = 1'b1;
                end
                MEMWR: begin
                    ctrl.lord     = 1'b1;
                    ctrl.memwrite = 1'b1;
                end
                RTYPEEX: begin
                    ctrl.alusrca = 1'b1;
                    ctrl.aluop   = ALUOP_FUNCT;
                end
                RTYPEWB: begin
                    ctrl.regdst   = 1'b1;
                    ctrl.regwrite = 1'b1;
                end
                BEQEX: begin
                    ctrl.alusrca = 1'b1;
                    ctrl.aluop   = ALUOP_SUB;
                    ctrl.pcsrc   = 2'b01;
                    ctrl.branch  = 1'b1;
                end
                ADDIWB:  ctrl.regwrite = 1'b1;
                JEX: begin
                    ctrl.pcsrc   = 2'b10;
                    ctrl.pcwrite = 1'b1;
                end
`ifdef MC_BNE_EN
                BNEEX: begin
                    ctrl.alusrca   = 1'b1;
                    ctrl.aluop     = ALUOP_SUB;
                    ctrl.pcsrc     = 2'b01;
                    ctrl.branch_ne = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    aludec #(
        .ALU_DFLT(ALU_DFLT)
    ) u_aludec (
        .aluop      (ctrl.aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

    assign lord     = ctrl.lord;
    assign irwrite  = ctrl.irwrite;
    assign regdst   = ctrl.regdst;
    assign memtoreg = ctrl.memtoreg;
    assign regwrite = ctrl.regwrite;
    assign memwrite = ctrl.memwrite;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign pcsrc    = ctrl.pcsrc;
    assign pcen     = ctrl.pcwrite | (ctrl.branch & zero) | (ctrl.branch_ne & ~zero);
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each instruction queues its expected
// per-cycle state and control word, then the queue is drained one clock at a time.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       lord, irwrite, regdst, memtoreg, regwrite, memwrite, alusrca, pcen;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        z;
        logic [18:0] exp;
    } sb_t;
    sb_t sb_q[$];

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .lord       (lord),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .memwrite   (memwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .alucontrol (alucontrol),
        .pcsrc      (pcsrc),
        .pcen       (pcen),
        .state      (state)
    );

    always #5 clk = ~clk;

    wire [14:0] dut_ctrl = {lord, irwrite, regdst, memtoreg, regwrite, memwrite, alusrca,
                            alusrcb, alucontrol, pcsrc, pcen};
    wire [18:0] dut_vec  = {state, dut_ctrl};

    localparam logic [14:0] IDLE_CTRL = {7'b0000000, 2'b00, 3'b010, 2'b00, 1'b0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Field order: lord irwrite regdst memtoreg regwrite memwrite alusrca | alusrcb | alucontrol | pcsrc | pcen
    function automatic logic [14:0] exp_ctrl(input logic [3:0] st, input logic [5:0] f, input logic z);
        case (st)
            4'd0:  return {7'b0100000, 2'b01, 3'b010, 2'b00, 1'b1};
            4'd1:  return {7'b0000000, 2'b11, 3'b010, 2'b00, 1'b0};
            4'd2:  return {7'b0000001, 2'b10, 3'b010, 2'b00, 1'b0};
            4'd3:  return {7'b1000000, 2'b00, 3'b010, 2'b00, 1'b0};
            4'd4:  return {7'b0001100, 2'b00, 3'b010, 2'b00, 1'b0};
            4'd5:  return {7'b1000010, 2'b00, 3'b010, 2'b00, 1'b0};
            4'd6:  return {7'b0000001, 2'b00, rtype_alu(f), 2'b00, 1'b0};
            4'd7:  return {7'b0010100, 2'b00, 3'b010, 2'b00, 1'b0};
            4'd8:  return {7'b0000001, 2'b00, 3'b110, 2'b01, z};
            4'd9:  return {7'b0000001, 2'b10, 3'b010, 2'b00, 1'b0};
            4'd10: return {7'b0000100, 2'b00, 3'b010, 2'b00, 1'b0};
            4'd11: return {7'b0000000, 2'b00, 3'b010, 2'b10, 1'b1};
            4'd12: return {7'b0000001, 2'b00, 3'b110, 2'b01, ~z};
            default: return IDLE_CTRL;
        endcase
    endfunction

    // Starts just after a clock edge with the DUT in FETCH. path holds up to five
    // expected states, MSB nibble first; zv[i] is the zero flag driven in cycle i.
    task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                             input int n, input logic [19:0] path, input logic [4:0] zv);
        logic [3:0] st;
        sb_t        e;
        int         c;
        op    = o;
        funct = f;
        for (int i = 0; i < n; i++) begin
            st = path[19-4*i -: 4];
            sb_q.push_back('{z: zv[i], exp: {st, exp_ctrl(st, f, zv[i])}});
        end
        c = 0;
        while (sb_q.size() > 0) begin
            e    = sb_q.pop_front();
            zero = e.z;
            #1;
            check($sformatf("%s_c%0d", name, c), 32'(dut_vec), 32'(e.exp));
            c++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b0;
        op    = 6'b0;
        funct = 6'b0;
        zero  = 1'b0;
        #1;
        check("por_state", 32'(state), 32'd0);
        check("por_ctrl", 32'(dut_ctrl), 32'(IDLE_CTRL));
        @(posedge clk);
        #1;
        check("por_hold_ctrl", 32'(dut_ctrl), 32'(IDLE_CTRL));
        reset = 1'b1;

        run_instr("lw",      6'b100011, 6'b000000, 5, 20'h01234, 5'b00000);
        run_instr("lw_z1",   6'b100011, 6'b000000, 5, 20'h01234, 5'b11111);
        run_instr("sw",      6'b101011, 6'b000000, 4, 20'h01250, 5'b00000);
        run_instr("r_sub",   6'b000000, 6'b100010, 4, 20'h01670, 5'b00000);
        run_instr("r_slt",   6'b000000, 6'b101010, 4, 20'h01670, 5'b00000);
        run_instr("r_undef", 6'b000000, 6'b111111, 4, 20'h01670, 5'b00000);
        run_instr("r_or",    6'b000000, 6'b100101, 4, 20'h01670, 5'b00000);
        run_instr("addi",    6'b001000, 6'b000000, 4, 20'h019A0, 5'b00000);
        run_instr("beq_t",   6'b000100, 6'b000000, 3, 20'h01800, 5'b00100);
        run_instr("beq_nt",  6'b000100, 6'b000000, 3, 20'h01800, 5'b00000);
        run_instr("beq_zd",  6'b000100, 6'b000000, 3, 20'h01800, 5'b00010);
        run_instr("j",       6'b000010, 6'b000000, 3, 20'h01B00, 5'b00111);
        run_instr("op_bad",  6'b111111, 6'b000000, 2, 20'h01000, 5'b00000);
`ifdef MC_BNE_EN
        run_instr("bne_t",   6'b000101, 6'b000000, 3, 20'h01C00, 5'b00000);
        run_instr("bne_nt",  6'b000101, 6'b000000, 3, 20'h01C00, 5'b00100);
`else
        run_instr("bne_off", 6'b000101, 6'b000000, 2, 20'h01000, 5'b00000);
`endif

        // Abort an R-type in its execute state with an asynchronous reset.
        op    = 6'b000000;
        funct = 6'b100000;
        zero  = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("mid_pre_state", 32'(state), 32'd6);
        reset = 1'b0;
        #1;
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_ctrl", 32'(dut_ctrl), 32'(IDLE_CTRL));
        @(posedge clk);
        #1;
        check("mid_hold_state", 32'(state), 32'd0);
        check("mid_hold_ctrl", 32'(dut_ctrl), 32'(IDLE_CTRL));
        reset = 1'b1;
        run_instr("post_rst_add", 6'b000000, 6'b100000, 4, 20'h01670, 5'b00000);
        run_instr("post_rst_and", 6'b000000, 6'b100100, 4, 20'h01670, 5'b00000);

        #1;
        check("end_state", 32'(state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multicycle MIPS datapath.
- Consumes op/funct from the instruction register and zero from the ALU.
- Sequences every instruction through a Moore FSM and drives all datapath selects and write enables.
- Contains the main FSM plus an ALU decoder; sits directly upstream of the datapath.

Parameters:
- ALU_DFLT, 3'b010, alucontrol emitted for undefined funct codes under R-type (add).
- STATEW, 4, width of the state encoding and of the debug state output.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- op  input  6  instr[31:26]
- funct  input  6  instr[5:0]
- zero  input  1  ALU zero flag
- lord  output  1  memory address select: 0=pc, 1=aluout
- irwrite  output  1  instruction register enable
- regdst  output  1  write register select: 0=rt, 1=rd
- memtoreg  output  1  register write data select: 0=aluout, 1=data
- regwrite  output  1  register file write enable
- memwrite  output  1  data memory write enable
- alusrca  output  1  ALU srca select: 0=pc, 1=A
- alusrcb  output  2  ALU srcb select: 00=B, 01=4, 10=signimm, 11=signimm<<2
- alucontrol  output  3  ALU operation
- pcsrc  output  2  next-pc select: 00=aluresult, 01=aluout, 10=jump target
- pcen  output  1  pc register enable
- state  output  STATEW  current state, for debug

Behaviour:
- Clock and reset: single clock; clk is the rising-edge clock, reset is asynchronous and active-low.
- Reset low: state <= FETCH immediately. irwrite, regwrite, memwrite, pcen forced 0; all selects 0; alucontrol=010.
- Reset release: first rising edge with reset high executes FETCH.
- Output timing: all outputs are combinational decodes of the state register (Moore), except pcen = pcwrite | (branch & zero).
- Defaults: any output not listed for a state is 0.
- FETCH (0): lord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1. Next: DECODE.
- DECODE (1): alusrca=0, alusrcb=11, aluop=00. Next by op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> RTYPEEX
  - 000100 -> BEQEX
  - 001000 -> ADDIEX
  - 000010 -> JEX
  - any other op -> FETCH (treated as nop; pc already advanced)
- MEMADR (2): alusrca=1, alusrcb=10, aluop=00. Next: MEMRD if op=100011, else MEMWR.
- MEMRD (3): lord=1. Next: MEMWB.
- MEMWB (4): regdst=0, memtoreg=1, regwrite=1. Next: FETCH.
- MEMWR (5): lord=1, memwrite=1. Next: FETCH.
- RTYPEEX (6): alusrca=1, alusrcb=00, aluop=10. Next: RTYPEWB.
- RTYPEWB (7): regdst=1, memtoreg=0, regwrite=1. Next: FETCH.
- BEQEX (8): alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Next: FETCH.
- ADDIEX (9): alusrca=1, alusrcb=10, aluop=00. Next: ADDIWB.
- ADDIWB (10): regdst=0, memtoreg=0, regwrite=1. Next: FETCH.
- JEX (11): pcsrc=10, pcwrite=1. Next: FETCH.
- Unused encodings: next state FETCH, outputs at defaults.
- ALU decoder:
  - aluop=00 -> 010; aluop=01 -> 110; aluop=11 -> 010.
  - aluop=10 by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->ALU_DFLT.
- Instruction latencies (cycles): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, undefined op 2.
- Reset mid-instruction: FSM aborts and no write enable pulses after the reset edge.
- zero: sampled only in BEQEX; ignored in all other states.

Optional Feature:
- Macro: MC_BNE_EN.
- Defined:
  - op 000101 in DECODE -> BNEEX (12).
  - BNEEX outputs equal BEQEX, but pcen = pcwrite | (branch & ~zero).
  - Next: FETCH.
- Undefined: op 000101 is an undefined op (DECODE -> FETCH); encoding 12 unused.

Decomposition:
- Shared package mc_pkg:
  - state enum statetype (FETCH..BNEEX, STATEW bits)
  - opcode constants OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J, OP_BNE
  - funct constants
  - aluop constants
  - alucontrol constants ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
- Sub-module: aludec (aluop, funct -> alucontrol), purely combinational, instantiated once.
- Main FSM and output decode live in multicycle_controller.

Test Plan:
- Reset low mid-RTYPEEX -> state=0 immediately; irwrite=pcen=regwrite=memwrite=0; after release, cycle 1 shows irwrite=1, pcen=1, alusrcb=01.
- lw (op=100011) -> states 0,1,2,3,4; lord=1 in MEMRD; MEMWB has regwrite=1, memtoreg=1, regdst=0; back to FETCH on cycle 6.
- sw (op=101011) -> states 0,1,2,5; memwrite=1 only in MEMWR.
- R-type -> funct 100010: alucontrol=110 in RTYPEEX, regwrite=1 and regdst=1 in RTYPEWB. Funct 101010 -> 111. Funct 111111 -> 010.
- beq -> BEQEX with zero=1: pcen=1, pcsrc=01. With zero=0: pcen=0. zero=1 in DECODE: pcen=0.
- j -> JEX: pcsrc=10, pcen=1. Op 111111 -> DECODE returns to FETCH with no write enables. With MC_BNE_EN: op 000101, zero=0 -> pcen=1 in state 12.
